systolic_drain: RTL

Result collector at the output end of the systolic multiply array. Captures the skewed per-column results leaving the last row of `mcell` instances and re-aligns them into whole rows. Buffers the aligned rows in a small FIFO and hands them to the downstream consumer over a valid/ready handshake. This block is the counterpart of the input skew feeding the array: the feeder skews, the drain de-skews.

---
 rtl/systolic_drain_if.sv | 23 ++
 rtl/systolic_drain.sv | 118 +++++++++++
 2 files changed

// File: rtl/systolic_drain_if.sv
// rtl/systolic_drain_if.sv - skewed result input and aligned row output bundle for systolic_drain
interface systolic_drain_if #(
  parameter int DATA_SIZE  = 8,
  parameter int ARRAY_SIZE = 2
);
  localparam int RW = ARRAY_SIZE * 2 * DATA_SIZE;

  logic [RW-1:0] res_in;
  logic          res_valid;
  logic [RW-1:0] row_data;
  logic          row_valid;
  logic          row_ready;

  modport master (
    output res_in, res_valid, row_ready,
    input  row_data, row_valid
  );

  modport slave (
    input  res_in, res_valid, row_ready,
    output row_data, row_valid
  );
endinterface

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - de-skews systolic array column results into rows and buffers them in a FIFO
// Optional sticky drop flag built only when DRAIN_OVF_EN is defined.
module systolic_drain #(
  parameter int DATA_SIZE  = 8,
  parameter int ARRAY_SIZE = 2,
  parameter int DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  systolic_drain_if.slave   bus,
  output logic [7:0]        row_count,
  output logic              overflow
);
  localparam int EW = 2 * DATA_SIZE;
  localparam int RW = ARRAY_SIZE * EW;
  localparam int AW = $clog2(DEPTH);

  logic [RW-1:0] aligned;
  logic          aligned_valid;

  // Column j arrives j cycles after column 0, so it is delayed ARRAY_SIZE-1-j cycles to line up.
  genvar j;
  generate
    for (j = 0; j < ARRAY_SIZE; j++) begin : g_col
      localparam int NS = ARRAY_SIZE - 1 - j;
      if (NS == 0) begin : g_pass
        assign aligned[EW*j +: EW] = bus.res_in[EW*j +: EW];
      end else begin : g_dly
        logic [EW-1:0] stage [NS];
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            for (int s = 0; s < NS; s++) stage[s] <= '0;
          end else begin
            stage[0] <= bus.res_in[EW*j +: EW];
            for (int s = 1; s < NS; s++) stage[s] <= stage[s-1];
          end
        end
        assign aligned[EW*j +: EW] = stage[NS-1];
      end
    end

    if (ARRAY_SIZE == 1) begin : g_vpass
      assign aligned_valid = bus.res_valid;
    end else begin : g_vdly
      logic [ARRAY_SIZE-2:0] vpipe;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vpipe <= '0;
        end else if (clear) begin
          vpipe <= '0;
        end else begin
          vpipe[0] <= bus.res_valid;
          for (int s = 1; s < ARRAY_SIZE - 1; s++) vpipe[s] <= vpipe[s-1];
        end
      end
      assign aligned_valid = vpipe[ARRAY_SIZE-2];
    end
  endgenerate

  logic [RW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = !empty && bus.row_ready;
  assign push  = aligned_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= aligned;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      row_count <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      row_count <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        row_count <= row_count + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign bus.row_data  = mem[rd_ptr[AW-1:0]];
  assign bus.row_valid = !empty;

`ifdef DRAIN_OVF_EN
  logic ovf_q;
  logic drop;
  assign drop = aligned_valid && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif
endmodule
